// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a simple single-bus CPU datapath.
// A registered state walks through fetch (T0-T2) and an opcode-dependent
// execute phase (T3-T7); every datapath strobe is decoded combinationally
// from the registered state and the instruction register.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic [15:0] R_in,
  output logic [15:0] R_out,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowin,
  output logic        ZLowout,
  output logic        Cout,
  output logic [4:0]  OP,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
    S_STOPPED,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  // Instruction fields; the low 15 bits (immediate/offset) belong to the datapath.
  logic [4:0]  opcode;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        is_alu, is_imm, is_ld, is_st, is_halt, is_mem, has_exec;
  logic [4:0]  imm_op;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  assign ra_oh     = 16'd1 << IR[26:23];
  assign rb_oh     = 16'd1 << IR[22:19];
  assign rc_oh     = 16'd1 << IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu   = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_imm   = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_ld    = (opcode == 5'b00000);
  assign is_st    = (opcode == 5'b00010);
  assign is_halt  = (opcode == 5'b11011);
  assign is_mem   = is_ld || is_st;
  assign has_exec = is_alu || is_imm || is_mem;

  // Immediate forms reuse the ALU op of their register counterpart.
  always_comb begin
    imm_op = 5'b00000;
    case (opcode)
      5'b01100: imm_op = 5'b00011;
      5'b01101: imm_op = 5'b00101;
      5'b01110: imm_op = 5'b00110;
      default:  imm_op = 5'b00000;
    endcase
  end

  // State register; Clear drops straight to RESET without waiting for a clock.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: Stop only matters on edges that would otherwise start a new fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:   state_d = Stop ? S_STOPPED : S_T0;
      S_T0:      state_d = S_T1;
      S_T1:      state_d = S_T2;
      S_T2:      state_d = S_T3;
      S_T3: begin
        if (has_exec)     state_d = S_T4;
        else if (is_halt) state_d = S_HALT;
        else              state_d = Stop ? S_STOPPED : S_T0;
      end
      S_T4:      state_d = S_T5;
      S_T5:      state_d = is_mem ? S_T6 : (Stop ? S_STOPPED : S_T0);
      S_T6:      state_d = S_T7;
      S_T7:      state_d = Stop ? S_STOPPED : S_T0;
      S_STOPPED: state_d = Stop ? S_STOPPED : S_T0;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
  end

  // Strobe decode: everything idles at 0 unless the current step names it.
  always_comb begin
    R_in    = 16'h0000;
    R_out   = 16'h0000;
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    ZLowin  = 1'b0;
    ZLowout = 1'b0;
    Cout    = 1'b0;
    OP      = 5'b00000;
    Run     = 1'b0;
    case (state_q)
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowin = 1'b1;
      end
      S_T1: begin
        Run = 1'b1; ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        if (has_exec) begin
          R_out = rb_oh;
          Yin   = 1'b1;
        end
      end
      S_T4: begin
        Run    = 1'b1;
        ZLowin = 1'b1;
        if (is_alu) begin
          R_out = rc_oh;
          OP    = opcode;
        end else if (is_imm) begin
          Cout = 1'b1;
          OP   = imm_op;
        end else if (is_mem) begin
          Cout = 1'b1;
          OP   = 5'b00011;
        end
      end
      S_T5: begin
        Run     = 1'b1;
        ZLowout = 1'b1;
        if (is_mem) MARin = 1'b1;
        else        R_in  = ra_oh;
      end
      S_T6: begin
        Run   = 1'b1;
        MDRin = 1'b1;
        if (is_ld) Read  = 1'b1;
        else       R_out = ra_oh;
      end
      S_T7: begin
        Run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1;
          R_in   = ra_oh;
        end else begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus side builds each
// instruction's expected per-cycle strobe pattern from the instruction
// class tables and queues it; the monitor pops and compares on every
// falling clock edge.
module tb_control_sequencer;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        Stop;
  logic [15:0] R_in, R_out;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
  logic        IRin, Yin, ZLowin, ZLowout, Cout, Run;
  logic [4:0]  OP;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
    .R_in(R_in), .R_out(R_out),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin), .ZLowout(ZLowout),
    .Cout(Cout), .OP(OP), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        run;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcout, pcin, incpc, marin, mdrin, mdrout, rd, wr;
    logic        irin, yin, zlowin, zlowout, cout;
    logic [4:0]  op;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } sb_t;

  sb_t  sb_q[$];
  out_t mseq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t sample();
    out_t a;
    a.run = Run; a.rin = R_in; a.rout = R_out;
    a.pcout = PCout; a.pcin = PCin; a.incpc = IncPC; a.marin = MARin;
    a.mdrin = MDRin; a.mdrout = MDRout; a.rd = Read; a.wr = Write;
    a.irin = IRin; a.yin = Yin; a.zlowin = ZLowin; a.zlowout = ZLowout;
    a.cout = Cout; a.op = OP;
    return a;
  endfunction

  function automatic out_t idle();
    out_t s;
    s = '0;
    return s;
  endfunction

  function automatic out_t active();
    out_t s;
    s = '0;
    s.run = 1'b1;
    return s;
  endfunction

  task automatic check(input string tag, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, a, e);
    end
  endtask

  task automatic push(input out_t v, input string tag);
    sb_t e;
    e.v = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference model: the full cycle-by-cycle pattern of one instruction, T0 onward.
  task automatic model(input logic [31:0] ir);
    logic [4:0]  opc;
    logic [15:0] ra, rb, rc;
    logic [4:0]  imm_ops [3];
    out_t        s;
    bit          alu, imm, ld, st;
    opc = ir[31:27];
    ra = 16'h0001 << ir[26:23];
    rb = 16'h0001 << ir[22:19];
    rc = 16'h0001 << ir[18:15];
    imm_ops[0] = 5'd3; imm_ops[1] = 5'd5; imm_ops[2] = 5'd6;
    alu = (opc >= 5'd3) && (opc <= 5'd11);
    imm = (opc >= 5'd12) && (opc <= 5'd14);
    ld  = (opc == 5'd0);
    st  = (opc == 5'd2);
    mseq.delete();
    s = active(); s.pcout = 1; s.marin = 1; s.incpc = 1; s.zlowin = 1; mseq.push_back(s);
    s = active(); s.zlowout = 1; s.pcin = 1; s.rd = 1; s.mdrin = 1;   mseq.push_back(s);
    s = active(); s.mdrout = 1; s.irin = 1;                           mseq.push_back(s);
    if (alu || imm || ld || st) begin
      s = active(); s.rout = rb; s.yin = 1; mseq.push_back(s);
      s = active(); s.zlowin = 1;
      if (alu) begin
        s.rout = rc; s.op = opc;
      end else if (imm) begin
        s.cout = 1; s.op = imm_ops[int'(opc) - 12];
      end else begin
        s.cout = 1; s.op = 5'd3;
      end
      mseq.push_back(s);
      s = active(); s.zlowout = 1;
      if (ld || st) s.marin = 1;
      else          s.rin = ra;
      mseq.push_back(s);
      if (ld) begin
        s = active(); s.rd = 1; s.mdrin = 1;    mseq.push_back(s);
        s = active(); s.mdrout = 1; s.rin = ra; mseq.push_back(s);
      end else if (st) begin
        s = active(); s.rout = ra; s.mdrin = 1; mseq.push_back(s);
        s = active(); s.wr = 1;                 mseq.push_back(s);
      end
    end else begin
      s = active(); mseq.push_back(s);
    end
  endtask

  // Called just after the edge entering T0; k>0 holds Stop through the instruction
  // and then k cycles of STOPPED before releasing it.
  task automatic run_instr(input logic [31:0] ir, input int k);
    IR   = ir;
    Stop = (k > 0);
    model(ir);
    foreach (mseq[i]) push(mseq[i], $sformatf("ir=%08h T%0d", ir, i));
    repeat (mseq.size()) tick();
    for (int j = 0; j < k; j++) begin
      push(idle(), $sformatf("ir=%08h stopped%0d", ir, j));
      if (j == k - 1) Stop = 1'b0;
      tick();
    end
  endtask

  // Monitor: one expected pattern per falling edge while the scoreboard has entries.
  always @(negedge Clock) begin
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, sample(), e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    int          k;

    // Reset: outputs idle while Clear is low, then T0 on the first edge after release.
    Clear = 1'b1; Stop = 1'b0; IR = 32'h0;
    #2 Clear = 1'b0;
    repeat (3) push(idle(), "reset");
    repeat (3) @(negedge Clock);
    #1 Clear = 1'b1;
    tick();

    run_instr(32'h409A8000, 0);   // shra R1,R3,R5
    run_instr(32'h61200005, 0);   // addi R2,R4,5
    run_instr(32'h00900010, 0);   // ld R1,0x10(R2)

    // Stop raised in T4 of shra: T5 still completes, then STOPPED.
    IR = 32'h409A8000; Stop = 1'b0;
    model(IR);
    foreach (mseq[i]) push(mseq[i], $sformatf("stopT4 T%0d", i));
    repeat (2) push(idle(), "stopT4 stopped");
    repeat (4) tick();
    Stop = 1'b1;
    tick();
    tick();
    tick();
    Stop = 1'b0;
    tick();

    run_instr(32'h11A00004, 2);   // st R3,4(R4) with Stop held throughout
    run_instr(32'hD0000000, 0);   // nop

    // halt: parks in HALT until a Clear pulse.
    IR = 32'hD8000000; Stop = 1'b0;
    model(IR);
    foreach (mseq[i]) push(mseq[i], $sformatf("halt T%0d", i));
    for (int j = 0; j < 11; j++) push(idle(), $sformatf("halted%0d", j));
    repeat (14) tick();
    Clear = 1'b0;
    #2 Clear = 1'b1;
    tick();

    run_instr(32'h409A8000, 0);

    // Clear mid-cycle in T6 of ld: strobes vanish before the next edge.
    IR = 32'h00900010; Stop = 1'b0;
    model(IR);
    for (int i = 0; i < 6; i++) push(mseq[i], $sformatf("abort T%0d", i));
    repeat (2) push(idle(), "abort reset");
    repeat (6) tick();
    check("abort T6 before clear", sample(), mseq[6]);
    #1 Clear = 1'b0;
    #1 check("abort async clear", sample(), idle());
    tick();
    @(negedge Clock);
    #1 Clear = 1'b1;
    tick();

    // Random instruction mix with occasional Stop pauses.
    for (int n = 0; n < 60; n++) begin
      ir = $urandom;
      if (ir[31:27] == 5'd27) ir[31:27] = 5'd26;
      if (n % 3 == 0) ir[31:27] = 5'($urandom_range(0, 14));
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(ir, k);
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain got %0d pending exp 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
